// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory with a ready/valid handshake.
// Requests are checked at acceptance; errors suppress the access.
module dmem_responder #(
  parameter int ADDR_BITS = 14,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic        mem_ready,
  output logic [31:0] dout,
  output logic        dout_valid,
  output logic        mem_error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t r_state;
  state_t w_next;

  logic [3:0]           r_cnt;
  logic [ADDR_BITS-1:0] r_idx;
  logic [31:0]          r_din;
  logic                 r_wr;
  logic                 r_err;
  logic [31:0]          r_dout;
  logic [31:0]          r_mem [2**ADDR_BITS];

  logic w_req;
  logic w_accept;
  logic w_access;
  logic w_err;

  assign w_req    = mem_read | mem_write;
  assign w_accept = (r_state == S_IDLE) & w_req;
  assign w_access = (r_state == S_BUSY) & (r_cnt == 4'd0);

  assign w_err = (addr[1:0] != 2'b00)
               | (|addr[31:ADDR_BITS+2])
               | (mem_read & mem_write);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_req) w_next = S_BUSY;
      S_BUSY: if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= 4'd0;
      r_idx  <= '0;
      r_din  <= 32'd0;
      r_wr   <= 1'b0;
      r_err  <= 1'b0;
      r_dout <= 32'd0;
    end else begin
      if (w_accept) begin
        r_cnt <= LAT_M1;
        r_idx <= addr[ADDR_BITS+1:2];
        r_din <= din;
        r_wr  <= mem_write;
        r_err <= w_err;
      end else if (r_state == S_BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Writes and faulted requests respond with zero data
      if (w_access) begin
        r_dout <= (!r_err && !r_wr) ? r_mem[r_idx] : 32'd0;
      end else if (r_state == S_RESP) begin
        r_dout <= 32'd0;
      end
    end
  end

  // Array is deliberately not reset; reset forces IDLE so no commit occurs
  always_ff @(posedge clk) begin
    if (w_access && r_wr && !r_err) begin
      r_mem[r_idx] <= r_din;
    end
  end

  assign mem_ready  = (r_state == S_IDLE);
  assign dout_valid = (r_state == S_RESP);
  assign mem_error  = (r_state == S_RESP) & r_err;
  assign dout       = r_dout;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder that serves the CPU's data-memory port (`addr`, `din`, `mem_read`, `mem_write`, `dout`) with a configurable access latency and an explicit ready/valid handshake. It replaces the zero-latency data memory when the core moves to a stalling datapath. The core raises a request while `mem_ready` is high and stalls until `dout_valid`. Out-of-range, misaligned and conflicting requests are reported through `mem_error`.

## Interface
- `ADDR_BITS`, 14: word-address width; the array holds 2^ADDR_BITS 32-bit words.
- `LATENCY`, 4: edges from request acceptance to the response cycle; legal range 1..15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset (asserted when 0).
- `mem_read` input 1: read request.
- `mem_write` input 1: write request.
- `addr` input 32: byte address; the word index is `addr[ADDR_BITS+1:2]`.
- `din` input 32: write data.
- `mem_ready` output 1: responder idle; a request is accepted on this edge.
- `dout` output 32: read data, valid only while `dout_valid` is high.
- `dout_valid` output 1: one-cycle response strobe, issued for reads and writes.
- `mem_error` output 1: error flag, qualified by `dout_valid`.

## Operation
- States: IDLE, BUSY, RESP. A 4-bit down-counter `cnt` tracks latency.
- IDLE
  - `mem_ready` is 1.
  - A request is accepted on an edge where `mem_ready && (mem_read || mem_write)`.
  - On acceptance the block latches `addr`, `din`, the op and the error check, loads `cnt` with LATENCY-1, and moves to BUSY.
- BUSY
  - On each edge with `cnt != 0`, `cnt` decrements.
  - On the edge with `cnt == 0`, the access is performed and the state moves to RESP.
  - A write commits to the array on this edge.
  - A read registers `mem[word]` into `dout` on this edge.
- RESP
  - `dout_valid` is 1 for exactly one cycle.
  - The next edge returns the state to IDLE.
- Errors are decided at acceptance. Any error suppresses the access: no array write, and `dout` is 0. `mem_error` is 1 in RESP. The error conditions are:
  - `addr[1:0] != 0` (misaligned);
  - `addr[31:ADDR_BITS+2] != 0` (out of range);
  - `mem_read && mem_write` both high.
- For a successful write, `dout` is 0 in RESP.
- Inputs are ignored outside IDLE. The latched request is not affected by input changes.
- Reset
  - While `reset` is 0: state IDLE, `cnt` = 0, `mem_ready` = 1, `dout_valid` = 0, `mem_error` = 0, `dout` = 0.
  - The array contents are not cleared by reset.
  - If reset is asserted in BUSY, the pending write is discarded. No partial write occurs, and no response is issued.

## Timing
- E0 is the acceptance edge.
  - `dout_valid`, `dout` and `mem_error` become valid after edge E_LATENCY and drop after E_LATENCY+1.
  - `mem_ready` falls after E0 and rises after E_LATENCY+1.
- Throughput is one request per LATENCY+2 cycles when requests are issued back to back.
- LATENCY=1: accept at E0, response after E1, ready after E2.
- All outputs are registered; there is no combinational path from inputs to outputs.
- A read issued immediately after a write to the same word returns the new data, because the write commits before the read is accepted.

## Test plan
- Write then read, LATENCY=4.
  - Stimulus: write `0xDEADBEEF` to `0x40`, then read `0x40`.
  - Required: `dout_valid` exactly 4 edges after each acceptance, `dout`=`0xDEADBEEF`, `mem_error`=0, `mem_ready` low for 5 cycles per request.
- Misaligned access.
  - Stimulus: write `0x12345678` to `0x42`, then read `0x40`.
  - Required: first response has `mem_error`=1; read returns the prior contents of word `0x40` unchanged.
- Conflicting request.
  - Stimulus: `mem_read`=`mem_write`=1 at `0x80` with `din`=`0xFFFFFFFF`.
  - Required: `mem_error`=1, `dout`=0; a follow-up read of `0x80` returns the old value.
- Out of range, ADDR_BITS=14.
  - Stimulus: read `0x0001_0000`.
  - Required: `mem_error`=1, `dout`=0.
- Busy-ignore.
  - Stimulus: while BUSY, toggle `mem_write` with a different `addr`/`din`.
  - Required: no second acceptance; only the original word changes.
- Reset mid-write.
  - Stimulus: write `0xA5A5A5A5` to `0x10` (previously `0x1`); assert `reset` low for 1 cycle at E2 (before LATENCY elapses).
  - Required: outputs go to their reset values immediately and no `dout_valid` is issued; a subsequent read of `0x10` returns `0x1`.
